// File: rtl/tact_debounce.sv
// ---------------------------------------------------------------------------
// tact_debounce
//
// Debouncer for a raw, bouncing push-button ("tact switch") input. The raw
// level is brought into the CLK_24MHz domain by a two-flop synchronizer. A
// four-state FSM then accepts a level change only after it has stayed stable
// for DB_CYCLES clocks. It reports the debounced level and emits one-cycle
// strobes when a press or a release is accepted.
//
// Optional feature, compiled in only when the macro TACT_LONG_PRESS_EN is
// defined: a long-press counter runs while the button is held. LONG_PULSE
// strobes once when a press has lasted LONG_CYCLES clocks. Without the macro
// that counter is not built and LONG_PULSE is tied to 0.
//
// Parameters
//   TACT_ON      Tact level that means "pressed" (released is ~TACT_ON)
//   W_DB         debounce counter width
//   DB_CYCLES    stable cycles needed to accept a change, 2..2^W_DB-1
//   W_LONG       long-press counter width (long-press build only)
//   LONG_CYCLES  held cycles before LONG_PULSE, 2..2^W_LONG-1
//
// Ports
//   CLK_24MHz      in   sole clock, rising edge
//   RESET_n        in   asynchronous active-low reset
//   Tact           in   raw asynchronous button level
//   PRESSED        out  debounced level, 1 = button held
//   PRESS_PULSE    out  one-cycle strobe on an accepted press
//   RELEASE_PULSE  out  one-cycle strobe on an accepted release
//   LONG_PULSE     out  one-cycle strobe when a press reaches LONG_CYCLES
//
// All outputs come straight from flops. Tact reaches no output through
// combinational logic.
// ---------------------------------------------------------------------------
module tact_debounce #(
  parameter logic TACT_ON     = 1'b0,
  parameter int   W_DB        = 16,
  parameter int   DB_CYCLES   = 24000,
  parameter int   W_LONG      = 24,
  parameter int   LONG_CYCLES = 12000000
) (
  input  logic CLK_24MHz,
  input  logic RESET_n,
  input  logic Tact,
  output logic PRESSED,
  output logic PRESS_PULSE,
  output logic RELEASE_PULSE,
  output logic LONG_PULSE
);

  // -------------------------------------------------------------------------
  // Elaboration-time parameter range checks
  // -------------------------------------------------------------------------
  if ((DB_CYCLES < 2) || (longint'(DB_CYCLES) > ((64'd1 << W_DB) - 64'd1))) begin : g_bad_db
    $error("tact_debounce: DB_CYCLES out of range for W_DB");
  end
  if ((LONG_CYCLES < 2) || (longint'(LONG_CYCLES) > ((64'd1 << W_LONG) - 64'd1))) begin : g_bad_long
    $error("tact_debounce: LONG_CYCLES out of range for W_LONG");
  end

  localparam logic            TACT_OFF = ~TACT_ON;
  localparam logic [W_DB-1:0] DB_LAST  = W_DB'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CHK   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CHK = 2'd3
  } state_e;

  // -------------------------------------------------------------------------
  // Two-flop synchronizer. Only sync2_q feeds the logic below.
  // -------------------------------------------------------------------------
  logic sync1_q;
  logic sync2_q;

  // NOTE: every clocked block uses non-blocking (<=) assignments. All flops
  // then sample their old values at the same edge. Blocking assignments here
  // would let sync2_q see this edge's sync1_q and remove one stage.
  always_ff @(posedge CLK_24MHz or negedge RESET_n) begin
    if (!RESET_n) begin
      // Reset to the released level, so that leaving reset never looks
      // like a press edge.
      sync1_q <= TACT_OFF;
      sync2_q <= TACT_OFF;
    end else begin
      sync1_q <= Tact;
      sync2_q <= sync1_q;
    end
  end

  logic s_pressed;
  assign s_pressed = (sync2_q == TACT_ON);

  // -------------------------------------------------------------------------
  // Debounce FSM
  // -------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [W_DB-1:0] cnt_q, cnt_d;
  logic            pressed_q, pressed_d;
  logic            press_pulse_q, press_pulse_d;
  logic            release_pulse_q, release_pulse_d;

  // NOTE: every signal this always_comb block writes gets a default first.
  // A path through the case that skipped an assignment would otherwise
  // infer a latch.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    pressed_d       = pressed_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (s_pressed) begin
          state_d = PRESS_CHK;
          cnt_d   = '0;
        end
      end

      PRESS_CHK: begin
        if (!s_pressed) begin
          // Glitch shorter than the debounce window: drop it silently.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d       = HELD;
          cnt_d         = '0;
          pressed_d     = 1'b1;
          press_pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      HELD: begin
        if (!s_pressed) begin
          state_d = RELEASE_CHK;
          cnt_d   = '0;
        end
      end

      RELEASE_CHK: begin
        if (s_pressed) begin
          // Release bounce: still held. No pulse, and the long-press
          // count carries on.
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d         = IDLE;
          cnt_d           = '0;
          pressed_d       = 1'b0;
          release_pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d   = IDLE;
        cnt_d     = '0;
        pressed_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK_24MHz or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      pressed_q       <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      pressed_q       <= pressed_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
    end
  end

  assign PRESSED       = pressed_q;
  assign PRESS_PULSE   = press_pulse_q;
  assign RELEASE_PULSE = release_pulse_q;

  // -------------------------------------------------------------------------
  // Long-press detection (optional)
  // -------------------------------------------------------------------------
`ifdef TACT_LONG_PRESS_EN
  localparam logic [W_LONG-1:0] LONG_LAST = W_LONG'(LONG_CYCLES - 1);

  logic [W_LONG-1:0] long_q, long_d;
  logic              long_done_q, long_done_d;
  logic              long_pulse_q, long_pulse_d;
  logic              enter_held;
  logic              release_accept;

  // A new press starts on the PRESS_CHK -> HELD edge. A release is final on
  // the RELEASE_CHK -> IDLE edge.
  assign enter_held     = (state_q == PRESS_CHK)   && (state_d == HELD);
  assign release_accept = (state_q == RELEASE_CHK) && (state_d == IDLE);

  always_comb begin
    long_d       = long_q;
    long_done_d  = long_done_q;
    long_pulse_d = 1'b0;

    if (enter_held) begin
      long_d      = '0;
      long_done_d = 1'b0;
    end else if ((state_q == HELD) || (state_q == RELEASE_CHK)) begin
      if (long_q != LONG_LAST) begin
        long_d = long_q + 1'b1;
      end else if (!long_done_q) begin
        // The count is saturated: fire once per press. If the release is
        // accepted on this same edge, the release strobe wins. The three
        // strobes never overlap.
        long_done_d  = 1'b1;
        long_pulse_d = !release_accept;
      end
    end
  end

  always_ff @(posedge CLK_24MHz or negedge RESET_n) begin
    if (!RESET_n) begin
      long_q       <= '0;
      long_done_q  <= 1'b0;
      long_pulse_q <= 1'b0;
    end else begin
      long_q       <= long_d;
      long_done_q  <= long_done_d;
      long_pulse_q <= long_pulse_d;
    end
  end

  assign LONG_PULSE = long_pulse_q;
`else
  assign LONG_PULSE = 1'b0;
`endif

endmodule

// File: tb/tb_tact_debounce.sv
// ---------------------------------------------------------------------------
// tb_tact_debounce
//
// Directed bench for tact_debounce with DB_CYCLES=4 and LONG_CYCLES=20.
// Inputs change 1 time unit after a rising edge. Outputs are checked at that
// same point, which is well away from both edges. Pulse counters sampled on
// the falling edge track how many strobes occurred and any overlap.
// ---------------------------------------------------------------------------
module tb_tact_debounce;

  localparam int DB_CYCLES   = 4;
  localparam int LONG_CYCLES = 20;

`ifdef TACT_LONG_PRESS_EN
  localparam int EXP_LONG = 1;
`else
  localparam int EXP_LONG = 0;
`endif

  logic clk;
  logic rst_n;
  logic tact;
  logic pressed;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;

  int n_cmp = 0;
  int n_err = 0;

  int press_cnt   = 0;
  int release_cnt = 0;
  int long_cnt    = 0;
  int overlap_cnt = 0;

  int p0;
  int r0;

  tact_debounce #(
    .TACT_ON    (1'b0),
    .W_DB       (16),
    .DB_CYCLES  (DB_CYCLES),
    .W_LONG     (24),
    .LONG_CYCLES(LONG_CYCLES)
  ) dut (
    .CLK_24MHz    (clk),
    .RESET_n      (rst_n),
    .Tact         (tact),
    .PRESSED      (pressed),
    .PRESS_PULSE  (press_pulse),
    .RELEASE_PULSE(release_pulse),
    .LONG_PULSE   (long_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (press_pulse)   press_cnt++;
    if (release_pulse) release_cnt++;
    if (long_pulse)    long_cnt++;
    if ((int'(press_pulse) + int'(release_pulse) + int'(long_pulse)) > 1) overlap_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    tact  = 1'b1;
    repeat (3) tick();
    check("rst_pressed",       32'(pressed),       0);
    check("rst_press_pulse",   32'(press_pulse),   0);
    check("rst_release_pulse", 32'(release_pulse), 0);
    check("rst_long_pulse",    32'(long_pulse),    0);
    rst_n = 1'b1;
    repeat (5) tick();
    check("idle_pressed", 32'(pressed), 0);

    // Clean press. k0 is the next edge, and the strobe follows edge k0+6.
    p0   = press_cnt;
    tact = 1'b0;
    repeat (6) tick();
    check("press_k5_pulse",   32'(press_pulse), 0);
    check("press_k5_pressed", 32'(pressed),     0);
    tick();
    check("press_k6_pulse",   32'(press_pulse),   1);
    check("press_k6_pressed", 32'(pressed),       1);
    check("press_k6_release", 32'(release_pulse), 0);
    tick();
    check("press_k7_pulse",   32'(press_pulse), 0);
    check("press_k7_pressed", 32'(pressed),     1);

    // Long press: the strobe is 20 cycles after PRESS_PULSE (edge E+20).
    repeat (18) tick();
    check("long_e19", 32'(long_pulse), 0);
    tick();
    check("long_e20", 32'(long_pulse), EXP_LONG);
    tick();
    check("long_e21", 32'(long_pulse), 0);
    repeat (20) tick();
    check("press_single", 32'(press_cnt - p0), 1);
    check("long_once",    32'(long_cnt),       EXP_LONG);
    check("held_pressed", 32'(pressed),        1);

    // Release bounce: 2 cycles high, then low again.
    r0   = release_cnt;
    tact = 1'b1;
    repeat (2) tick();
    tact = 1'b0;
    repeat (8) tick();
    check("bounce_pressed", 32'(pressed),          1);
    check("bounce_no_rel",  32'(release_cnt - r0), 0);

    // Clean release with the same latency as a press.
    tact = 1'b1;
    repeat (6) tick();
    check("rel_j5_pulse",   32'(release_pulse), 0);
    check("rel_j5_pressed", 32'(pressed),       1);
    tick();
    check("rel_j6_pulse",   32'(release_pulse), 1);
    check("rel_j6_pressed", 32'(pressed),       0);
    tick();
    check("rel_j7_pulse", 32'(release_pulse), 0);
    repeat (3) tick();
    check("rel_single",  32'(release_cnt - r0), 1);
    check("rel_pressed", 32'(pressed),          0);

    // Press glitch of 3 cycles: rejected.
    p0   = press_cnt;
    tact = 1'b0;
    repeat (3) tick();
    tact = 1'b1;
    repeat (10) tick();
    check("glitch_pressed",  32'(pressed),         0);
    check("glitch_no_press", 32'(press_cnt - p0),  0);

    // The FSM is back in IDLE, so a fresh press has the full latency.
    tact = 1'b0;
    repeat (6) tick();
    check("repress_k5_pulse", 32'(press_pulse), 0);
    tick();
    check("repress_k6_pulse", 32'(press_pulse), 1);
    repeat (3) tick();
    check("repress_pressed", 32'(pressed), 1);

    // Reset mid-press: outputs drop at once and no release strobe appears.
    r0 = release_cnt;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_pressed",       32'(pressed),       0);
    check("midrst_press_pulse",   32'(press_pulse),   0);
    check("midrst_release_pulse", 32'(release_pulse), 0);
    check("midrst_long_pulse",    32'(long_pulse),    0);
    tick();
    tick();
    check("midrst_hold_pressed", 32'(pressed), 0);
    rst_n = 1'b1;
    check("midrst_no_release", 32'(release_cnt - r0), 0);

    // Button still held after reset: PRESS_PULSE follows the 7th edge.
    repeat (6) tick();
    check("postrst_e6_pulse", 32'(press_pulse), 0);
    tick();
    check("postrst_e7_pulse",   32'(press_pulse), 1);
    check("postrst_e7_pressed", 32'(pressed),     1);
    tick();

    check("no_overlap", 32'(overlap_cnt), 0);
    check("long_total", 32'(long_cnt),    EXP_LONG);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
